// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters
// and a registered misprediction redirect/counter stage.
module branch_predictor #(
  parameter int ADDR_W  = 64,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              up_valid,
  input  logic [ADDR_W-1:0] up_pc,
  input  logic              up_taken,
  input  logic [ADDR_W-1:0] up_target,
  input  logic              up_pred_taken,
  input  logic [ADDR_W-1:0] up_pred_target,
  input  logic              flush,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [ENTRIES-1:0] valid_mem;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [ADDR_W-1:0]  target_mem [ENTRIES];
  logic [CNT_W-1:0]   cnt_mem    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic              vld_p0;
  logic              mispred_p0;
  logic [ADDR_W-1:0] correct_pc_p0;
  logic              mispredict_p1;
  logic [ADDR_W-1:0] redirect_pc_p1;
  logic [31:0]       mispredict_cnt_p1;

  // Stage p0: combinational lookup; reads see the table as of the last edge
  always_comb begin
    lk_idx    = lk_pc[IDX_W+1:2];
    lk_tag    = lk_pc[ADDR_W-1:IDX_W+2];
    lk_hit    = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    lk_taken  = lk_hit && cnt_mem[lk_idx][CNT_W-1];
    lk_target = lk_hit ? target_mem[lk_idx] : lk_pc + PC_STEP;
  end

  always_comb begin
    vld_p0        = up_valid;
    up_idx        = up_pc[IDX_W+1:2];
    up_tag        = up_pc[ADDR_W-1:IDX_W+2];
    up_hit        = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);
    correct_pc_p0 = up_taken ? up_target : up_pc + PC_STEP;
    mispred_p0    = vld_p0 && ((up_taken != up_pred_taken) ||
                               (up_taken && up_pred_taken && (up_target != up_pred_target)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_mem <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_mem[i] <= CNT_WEAK_NT;
    end else if (flush) begin
      valid_mem <= '0;
    end else if (vld_p0) begin
      if (up_hit) begin
        cnt_mem[up_idx] <= up_taken ? sat_inc(cnt_mem[up_idx]) : sat_dec(cnt_mem[up_idx]);
      end else if (up_taken) begin
        valid_mem[up_idx] <= 1'b1;
        cnt_mem[up_idx]   <= CNT_WEAK_T;
      end
    end
  end

  // Tag/target payload is only meaningful behind a valid bit, so it carries no reset
  always_ff @(posedge clk) begin
    if (rst && !flush && vld_p0 && up_taken) begin
      tag_mem[up_idx]    <= up_tag;
      target_mem[up_idx] <= up_target;
    end
  end

  // Stage p1: registered redirect and misprediction statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict_p1     <= 1'b0;
      redirect_pc_p1    <= '0;
      mispredict_cnt_p1 <= '0;
    end else begin
      mispredict_p1 <= mispred_p0;
      if (mispred_p0) begin
        redirect_pc_p1    <= correct_pc_p0;
        mispredict_cnt_p1 <= sat_inc32(mispredict_cnt_p1);
      end
    end
  end

  assign mispredict     = mispredict_p1;
  assign redirect_pc    = redirect_pc_p1;
  assign mispredict_cnt = mispredict_cnt_p1;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, counter saturation, aliasing,
// read-old, flush and wrap behaviour with hand-computed expectations.
module tb_branch_predictor;

  localparam int ADDR_W  = 64;
  localparam int ENTRIES = 16;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic              up_valid;
  logic [ADDR_W-1:0] up_pc;
  logic              up_taken;
  logic [ADDR_W-1:0] up_target;
  logic              up_pred_taken;
  logic [ADDR_W-1:0] up_pred_target;
  logic              flush;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       mispredict_cnt;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
    .up_pred_taken(up_pred_taken), .up_pred_target(up_pred_target),
    .flush(flush), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [63:0] pc, input string tag,
                      input logic hit, input logic taken, input logic [63:0] tgt);
    lk_pc = pc;
    #1;
    check({tag, "_hit"}, 64'(lk_hit), 64'(hit));
    check({tag, "_taken"}, 64'(lk_taken), 64'(taken));
    check({tag, "_target"}, lk_target, tgt);
  endtask

  task automatic upd(input logic [63:0] pc, input logic taken, input logic [63:0] tgt,
                     input logic ptaken, input logic [63:0] ptgt, input logic fl);
    up_pc = pc; up_taken = taken; up_target = tgt;
    up_pred_taken = ptaken; up_pred_target = ptgt;
    up_valid = 1'b1; flush = fl;
    @(posedge clk);
    #1;
    up_valid = 1'b0; flush = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; lk_pc = 64'h100; up_valid = 1'b0; up_pc = '0; up_taken = 1'b0;
    up_target = '0; up_pred_taken = 1'b0; up_pred_target = '0; flush = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    look(64'h100, "in_reset", 1'b0, 1'b0, 64'h104);
    check("in_reset_mp", 64'(mispredict), 64'd0);
    check("in_reset_redir", redirect_pc, 64'd0);
    check("in_reset_cnt", 64'(mispredict_cnt), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    look(64'h100, "post_reset", 1'b0, 1'b0, 64'h104);

    // First allocation, predicted not-taken
    upd(64'h100, 1'b1, 64'h40, 1'b0, 64'h104, 1'b0);
    check("alloc_mp", 64'(mispredict), 64'd1);
    check("alloc_redir", redirect_pc, 64'h40);
    check("alloc_cnt", 64'(mispredict_cnt), 64'd1);
    look(64'h100, "alloc", 1'b1, 1'b1, 64'h40);
    @(posedge clk);
    #1;
    check("idle_mp", 64'(mispredict), 64'd0);
    check("idle_redir_hold", redirect_pc, 64'h40);

    // Not-taken run drives the counter down to 0 and holds it there
    upd(64'h100, 1'b0, 64'h0, 1'b1, 64'h40, 1'b0);
    check("nt1_mp", 64'(mispredict), 64'd1);
    check("nt1_redir", redirect_pc, 64'h104);
    upd(64'h100, 1'b0, 64'h0, 1'b0, 64'h104, 1'b0);
    upd(64'h100, 1'b0, 64'h0, 1'b0, 64'h104, 1'b0);
    upd(64'h100, 1'b0, 64'h0, 1'b0, 64'h104, 1'b0);
    check("nt4_mp", 64'(mispredict), 64'd0);
    check("nt4_cnt", 64'(mispredict_cnt), 64'd2);
    look(64'h100, "nt4", 1'b1, 1'b0, 64'h40);
    upd(64'h100, 1'b0, 64'h0, 1'b0, 64'h104, 1'b0);
    check("nt5_cnt", 64'(mispredict_cnt), 64'd2);
    upd(64'h100, 1'b1, 64'h40, 1'b0, 64'h104, 1'b0);
    look(64'h100, "ctr_one", 1'b1, 1'b0, 64'h40);
    check("ctr_one_cnt", 64'(mispredict_cnt), 64'd3);

    // Counter climbs and saturates at 3; target mismatch counts as misprediction
    upd(64'h100, 1'b1, 64'h40, 1'b0, 64'h104, 1'b0);
    look(64'h100, "ctr_two", 1'b1, 1'b1, 64'h40);
    upd(64'h100, 1'b1, 64'h40, 1'b1, 64'h40, 1'b0);
    check("correct_mp", 64'(mispredict), 64'd0);
    check("correct_cnt", 64'(mispredict_cnt), 64'd4);
    upd(64'h100, 1'b1, 64'h80, 1'b1, 64'h40, 1'b0);
    check("tgt_mp", 64'(mispredict), 64'd1);
    check("tgt_redir", redirect_pc, 64'h80);
    check("tgt_cnt", 64'(mispredict_cnt), 64'd5);
    look(64'h100, "ctr_sat", 1'b1, 1'b1, 64'h80);
    upd(64'h100, 1'b0, 64'h0, 1'b1, 64'h80, 1'b0);
    look(64'h100, "ctr_hyst", 1'b1, 1'b1, 64'h80);
    check("hyst_cnt", 64'(mispredict_cnt), 64'd6);

    // Alias replaces the entry at the same index
    upd(64'h100 + 64'(4 * ENTRIES), 1'b1, 64'h300, 1'b0, 64'h144, 1'b0);
    look(64'h100, "alias_old", 1'b0, 1'b0, 64'h104);
    look(64'h140, "alias_new", 1'b1, 1'b1, 64'h300);
    check("alias_cnt", 64'(mispredict_cnt), 64'd7);

    // Read-old on same-cycle lookup/update
    lk_pc = 64'h200;
    up_pc = 64'h200; up_taken = 1'b1; up_target = 64'h500;
    up_pred_taken = 1'b0; up_pred_target = 64'h204; up_valid = 1'b1;
    #1;
    check("readold_hit", 64'(lk_hit), 64'd0);
    check("readold_target", lk_target, 64'h204);
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    #1;
    look(64'h200, "after_write", 1'b1, 1'b1, 64'h500);

    // Flush wins over a simultaneous allocating update
    upd(64'h300, 1'b1, 64'h600, 1'b0, 64'h304, 1'b1);
    check("flush_mp", 64'(mispredict), 64'd1);
    check("flush_redir", redirect_pc, 64'h600);
    check("flush_cnt", 64'(mispredict_cnt), 64'd9);
    look(64'h200, "flush_200", 1'b0, 1'b0, 64'h204);
    look(64'h140, "flush_140", 1'b0, 1'b0, 64'h144);
    look(64'h300, "flush_300", 1'b0, 1'b0, 64'h304);

    // PC+4 wraps at the top of the address space; not-taken miss leaves table alone
    upd(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b1, 64'h1234, 1'b0);
    check("wrap_mp", 64'(mispredict), 64'd1);
    check("wrap_redir", redirect_pc, 64'd0);
    check("wrap_cnt", 64'(mispredict_cnt), 64'd10);
    look(64'hFFFF_FFFF_FFFF_FFFC, "wrap_lk", 1'b0, 1'b0, 64'd0);

    // Reset arriving during an update aborts it
    up_pc = 64'h400; up_taken = 1'b1; up_target = 64'h700;
    up_pred_taken = 1'b0; up_pred_target = 64'h404; up_valid = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    rst = 1'b1;
    #1;
    look(64'h400, "rst_abort", 1'b0, 1'b0, 64'h404);
    check("rst_abort_mp", 64'(mispredict), 64'd0);
    check("rst_abort_redir", redirect_pc, 64'd0);
    check("rst_abort_cnt", 64'(mispredict_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
